// File: rtl/hss_sample_streamer.sv
// Sample FIFO written by the CPU and replayed as a paced, backpressure-aware
// AXI-Stream master into the HSS filter chain.
module hss_sample_streamer #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned PACE_DIV = 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_last,
  input  logic                     stream_en,
  input  logic                     flush,
  input  logic                     ovf_clr,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [DATA_W-1:0]        m_axis_data_tdata,
  output logic                     m_axis_data_tlast,
  output logic                     m_axis_data_tvalid,
  input  logic                     m_axis_data_tready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;
  localparam logic [PW-1:0] PACE_RELOAD = PW'(PACE_DIV - 1);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     pace_q, pace_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tlast_q, tlast_d;
  logic              tvalid_q, tvalid_d;
  logic [DATA_W:0]   mem_q [DEPTH];
  logic [DATA_W:0]   head;

  logic full, empty, push, pop, reg_free, load, ovf_evt;

  // Status comes straight from the pointer registers, so it reflects the
  // previous edge and never the current cycle's strobes.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign push     = wr_en && !full && !flush;
  assign ovf_evt  = wr_en && full && !flush;
  assign reg_free = !tvalid_q || m_axis_data_tready;
  assign load     = reg_free && !empty && stream_en && (pace_q == '0);
  assign pop      = load;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pace_d   = pace_q;
    ovf_d    = ovf_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    if (load) begin
      pace_d = PACE_RELOAD;
    end else if (pace_q != '0) begin
      pace_d = pace_q - 1'b1;
    end

    // A new drop event outranks a clear in the same cycle.
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end

    // The head is read before the flush takes effect, so a coincident load
    // still launches the pre-flush entry.
    if (load) begin
      tdata_d  = head[DATA_W-1:0];
      tlast_d  = head[DATA_W];
      tvalid_d = 1'b1;
    end else if (reg_free) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pace_q   <= '0;
      ovf_q    <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pace_q   <= pace_d;
      ovf_q    <= ovf_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {wr_last, wr_data};
    end
  end

  assign fifo_full          = full;
  assign fifo_empty         = empty;
  assign fifo_level         = wr_ptr_q - rd_ptr_q;
  assign overflow           = ovf_q;
  assign m_axis_data_tdata  = tdata_q;
  assign m_axis_data_tlast  = tlast_q;
  assign m_axis_data_tvalid = tvalid_q;

endmodule

// File: tb/tb_hss_sample_streamer.sv
// Directed bench for hss_sample_streamer: a back-to-back instance and a
// PACE_DIV=4 instance share the same stimulus.
module tb_hss_sample_streamer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_last = 1'b0;
  logic        stream_en = 1'b0;
  logic        flush = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        tready = 1'b0;

  logic        full, empty, ovf, tvalid, tlast;
  logic [4:0]  level;
  logic [31:0] tdata;
  logic        full_p4, empty_p4, ovf_p4, tvalid_p4, tlast_p4;
  logic [4:0]  level_p4;
  logic [31:0] tdata_p4;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  hss_sample_streamer #(.DATA_W(32), .DEPTH(16), .PACE_DIV(1)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .wr_en(wr_en), .wr_data(wr_data),
    .wr_last(wr_last), .stream_en(stream_en), .flush(flush), .ovf_clr(ovf_clr),
    .fifo_full(full), .fifo_empty(empty), .fifo_level(level), .overflow(ovf),
    .m_axis_data_tdata(tdata), .m_axis_data_tlast(tlast),
    .m_axis_data_tvalid(tvalid), .m_axis_data_tready(tready)
  );

  hss_sample_streamer #(.DATA_W(32), .DEPTH(16), .PACE_DIV(4)) u_dut_p4 (
    .aclk(aclk), .aresetn(aresetn), .wr_en(wr_en), .wr_data(wr_data),
    .wr_last(wr_last), .stream_en(stream_en), .flush(flush), .ovf_clr(ovf_clr),
    .fifo_full(full_p4), .fifo_empty(empty_p4), .fifo_level(level_p4),
    .overflow(ovf_p4), .m_axis_data_tdata(tdata_p4), .m_axis_data_tlast(tlast_p4),
    .m_axis_data_tvalid(tvalid_p4), .m_axis_data_tready(tready)
  );

  typedef struct {
    logic        we;
    logic [31:0] d;
    logic        l;
    logic        se;
    logic        tr;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic [4:0]  lv;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic we, logic [31:0] d, logic l, logic se, logic tr,
                              logic ev, logic [31:0] ed, logic el, logic [4:0] lv);
    vec_t v;
    v.we = we; v.d = d; v.l = l; v.se = se; v.tr = tr;
    v.ev = ev; v.ed = ed; v.el = el; v.lv = lv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0; stream_en = 1'b0; tready = 1'b0;
    aresetn = 1'b1;
    step();
    step();
    aresetn = 1'b0;
    step();
  endtask

  int          beat_cyc[$];
  logic [31:0] beat_dat[$];
  logic [31:0] exp_q[$];

  initial begin
    // Back-to-back burst, then backpressure on a fresh sample pair.
    vecs[0]  = mk(1, 32'h1000, 0, 1, 1, 0, 32'h0,    0, 5'd1);
    vecs[1]  = mk(1, 32'h2000, 0, 1, 1, 1, 32'h1000, 0, 5'd1);
    vecs[2]  = mk(1, 32'h3000, 1, 1, 1, 1, 32'h2000, 0, 5'd1);
    vecs[3]  = mk(0, 32'h0,    0, 1, 1, 1, 32'h3000, 1, 5'd0);
    vecs[4]  = mk(0, 32'h0,    0, 1, 1, 0, 32'h0,    0, 5'd0);
    vecs[5]  = mk(1, 32'h1000, 0, 1, 0, 0, 32'h0,    0, 5'd1);
    vecs[6]  = mk(1, 32'h2000, 0, 1, 0, 1, 32'h1000, 0, 5'd1);
    for (int i = 7; i < 12; i++) vecs[i] = mk(0, 32'h0, 0, 1, 0, 1, 32'h1000, 0, 5'd1);
    vecs[12] = mk(0, 32'h0,    0, 1, 1, 1, 32'h2000, 0, 5'd0);
    vecs[13] = mk(0, 32'h0,    0, 1, 1, 0, 32'h0,    0, 5'd0);

    #2;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    step();
    aresetn = 1'b0;
    step();

    for (int i = 0; i < 14; i++) begin
      wr_en = vecs[i].we; wr_data = vecs[i].d; wr_last = vecs[i].l;
      stream_en = vecs[i].se; tready = vecs[i].tr;
      step();
      chk($sformatf("vec%0d_tvalid", i), tvalid, vecs[i].ev);
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_tdata", i), tdata, vecs[i].ed);
        chk($sformatf("vec%0d_tlast", i), tlast, vecs[i].el);
      end
      chk($sformatf("vec%0d_level", i), level, vecs[i].lv);
      chk($sformatf("vec%0d_empty", i), empty, vecs[i].lv == 0);
      chk($sformatf("vec%0d_full", i), full, 0);
    end
    wr_en = 1'b0; wr_last = 1'b0;

    // Pacing: four queued samples, PACE_DIV=4, tready held high.
    do_reset();
    tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 32'hA0 + i;
      step();
    end
    wr_en = 1'b0;
    chk("pace_level", level_p4, 4);
    stream_en = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (tvalid_p4) begin
        beat_cyc.push_back(c);
        beat_dat.push_back(tdata_p4);
      end
    end
    chk("pace_beats", beat_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < beat_cyc.size()) begin
        chk($sformatf("pace_cyc%0d", i), beat_cyc[i], 4 * i);
        chk($sformatf("pace_dat%0d", i), beat_dat[i], 32'hA0 + i);
      end
    end

    // stream_en gap around a held beat on the paced instance.
    tready = 1'b0; stream_en = 1'b1;
    wr_en = 1'b1; wr_data = 32'hB0;
    step();
    wr_data = 32'hB1;
    step();
    wr_en = 1'b0;
    chk("gap_load_valid", tvalid_p4, 1);
    chk("gap_load_data", tdata_p4, 32'hB0);
    stream_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("gap_hold_valid%0d", i), tvalid_p4, 1);
      chk($sformatf("gap_hold_data%0d", i), tdata_p4, 32'hB0);
    end
    tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("gap_idle_valid%0d", i), tvalid_p4, 0);
    end
    stream_en = 1'b1;
    step();
    chk("gap_next_valid", tvalid_p4, 1);
    chk("gap_next_data", tdata_p4, 32'hB1);

    // Asynchronous reset with an open handshake.
    tready = 1'b0;
    wr_en = 1'b1; wr_data = 32'hC0;
    step();
    wr_data = 32'hC1;
    step();
    wr_en = 1'b0;
    chk("arst_pre_valid", tvalid, 1);
    #2 aresetn = 1'b1;
    #1;
    chk("arst_tvalid", tvalid, 0);
    chk("arst_tdata", tdata, 0);
    chk("arst_level", level, 0);
    chk("arst_empty", empty, 1);
    chk("arst_ovf", ovf, 0);
    #1 aresetn = 1'b0;
    stream_en = 1'b0;
    wr_en = 1'b1; wr_data = 32'hC2;
    step();
    wr_en = 1'b0;
    chk("arst_post_level", level, 1);

    // Overflow: 18 writes into a stalled 16-deep FIFO.
    do_reset();
    stream_en = 1'b1; tready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'b1; wr_data = 32'h100 + i;
      step();
    end
    wr_en = 1'b0;
    chk("ovf_full", full, 1);
    chk("ovf_level", level, 16);
    chk("ovf_flag", ovf, 1);
    chk("ovf_head", tdata, 32'h100);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 0);
    wr_en = 1'b1; wr_data = 32'h200; tready = 1'b1;
    step();
    chk("ovf_pop_drop_flag", ovf, 1);
    chk("ovf_pop_level", level, 15);
    chk("ovf_pop_data", tdata, 32'h101);
    wr_data = 32'h201; tready = 1'b0; ovf_clr = 1'b1;
    step();
    chk("ovf_turn_level", level, 16);
    chk("ovf_turn_full", full, 1);
    chk("ovf_turn_clr", ovf, 0);
    wr_data = 32'h202;
    step();
    wr_en = 1'b0; ovf_clr = 1'b0;
    chk("ovf_set_wins", ovf, 1);
    chk("ovf_set_level", level, 16);
    for (int i = 1; i <= 16; i++) exp_q.push_back(32'h100 + i);
    exp_q.push_back(32'h201);
    tready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("drain_valid%0d", i), tvalid, 1);
      chk($sformatf("drain_data%0d", i), tdata, exp_q[i]);
      step();
    end
    chk("drain_end_valid", tvalid, 0);
    chk("drain_end_empty", empty, 1);

    // Flush with a coincident write and a held beat.
    do_reset();
    stream_en = 1'b1; tready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_data = 32'h300 + i;
      step();
    end
    chk("flush_pre_level", level, 8);
    wr_data = 32'h3FF; flush = 1'b1;
    step();
    wr_en = 1'b0; flush = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    chk("flush_ovf", ovf, 0);
    chk("flush_held_valid", tvalid, 1);
    chk("flush_held_data", tdata, 32'h300);
    tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("flush_after_valid%0d", i), tvalid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
